// File: rtl/synth_frame_receiver_if.sv
// Protocol types for the MCU->FPGA control link and the byte-stream /
// live-config interface between the SPI front-end and the frame receiver.

`ifndef N_OSCILLATORS
`define N_OSCILLATORS 2
`endif
`ifndef ENVELOPE_LEN
`define ENVELOPE_LEN 2
`endif

package protocol_pkg;
  localparam int N_OSC   = `N_OSCILLATORS;
  localparam int ENV_LEN = `ENVELOPE_LEN;

  typedef enum logic [1:0] {
    SIN      = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } shape_t;

  typedef struct packed {
    logic [31:0] rate;
    logic [31:0] duration;
  } envelope_t;

  typedef struct packed {
    envelope_t [ENV_LEN-1:0] envelopes;
    logic [31:0]             freq;
    shape_t                  shape;
  } wave_gen_t;

  typedef struct packed {
    wave_gen_t [N_OSC-1:0] wave_gens;
    logic [31:0]           reverb;
    logic [31:0]           volume;
  } synth_t;

  function automatic synth_t reset_synth_t();
    synth_t s;
    s = '0;
    for (int i = 0; i < N_OSC; i++) s.wave_gens[i].shape = SIN;
    return s;
  endfunction
endpackage

interface synth_frame_receiver_if;
  import protocol_pkg::*;

  logic        frame_active;
  logic        byte_valid;
  logic [7:0]  byte_data;
  synth_t      synth;
  logic        synth_valid;
  logic        frame_error;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    output frame_active, byte_valid, byte_data,
    input  synth, synth_valid, frame_error, err_code, busy
  );

  modport slave (
    input  frame_active, byte_valid, byte_data,
    output synth, synth_valid, frame_error, err_code, busy
  );
endinterface

// File: rtl/synth_frame_receiver.sv
// Assembles a synth_t from the SPI byte stream into a shadow copy and commits
// it to the live config only after a complete, checksum-clean frame.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame open, waiting for frame_active
// RECV     | collecting payload bytes, then the checksum byte
// WAIT_END | checksum seen, waiting for frame_active to drop
// DISCARD  | frame already rejected, swallowing bytes until frame end

module synth_frame_receiver
  import protocol_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  synth_frame_receiver_if.slave  bus
);

  localparam int STRIDE = 2*ENV_LEN + 2;
  localparam int NWORDS = N_OSC*STRIDE + 2;
  localparam int NBYTES = 4*NWORDS;
  localparam int BCW    = $clog2(NBYTES + 2);
  localparam int TCW    = $clog2(IDLE_TIMEOUT + 1);
  localparam int WIW    = BCW - 2;

  localparam logic [2:0] ERR_SHORT    = 3'd1;
  localparam logic [2:0] ERR_LONG     = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {IDLE, RECV, WAIT_END, DISCARD} state_t;

  state_t           state;
  logic [BCW-1:0]   byte_cnt;
  logic [7:0]       csum;
  logic [23:0]      word_acc;
  logic [TCW-1:0]   tmo_left;
  logic             ok;
  synth_t           shadow;
  synth_t           synth_q;
  logic             synth_valid_q;
  logic             frame_error_q;
  logic [2:0]       err_code_q;

  logic [31:0]      word_next;
  logic [WIW-1:0]   word_idx;
  logic             is_csum_byte;
  logic             word_wr;

  assign word_next    = {word_acc, bus.byte_data};
  assign word_idx     = byte_cnt[BCW-1:2];
  assign is_csum_byte = (byte_cnt == BCW'(NBYTES));
  assign word_wr      = (state == RECV) && bus.byte_valid && !is_csum_byte
                        && (byte_cnt[1:0] == 2'b11);

  // Frame sequencing, checksum/timeout tracking and the atomic commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      csum          <= '0;
      word_acc      <= '0;
      tmo_left      <= TCW'(IDLE_TIMEOUT);
      ok            <= 1'b0;
      synth_q       <= reset_synth_t();
      synth_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= '0;
    end else begin
      synth_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_active) begin
            state    <= RECV;
            byte_cnt <= '0;
            csum     <= '0;
            tmo_left <= TCW'(IDLE_TIMEOUT);
          end
        end
        RECV: begin
          if (bus.byte_valid) begin
            tmo_left <= TCW'(IDLE_TIMEOUT);
            byte_cnt <= byte_cnt + BCW'(1);
            if (is_csum_byte) begin
              // The checksum byte may coincide with frame end; consume it first.
              if (!bus.frame_active) begin
                state <= IDLE;
                if (bus.byte_data == csum) begin
                  synth_q       <= shadow;
                  synth_valid_q <= 1'b1;
                end else begin
                  frame_error_q <= 1'b1;
                  err_code_q    <= ERR_CHECKSUM;
                end
              end else begin
                ok    <= (bus.byte_data == csum);
                state <= WAIT_END;
              end
            end else begin
              csum     <= csum ^ bus.byte_data;
              word_acc <= word_next[23:0];
              if (!bus.frame_active) begin
                state         <= IDLE;
                frame_error_q <= 1'b1;
                err_code_q    <= ERR_SHORT;
              end
            end
          end else if (!bus.frame_active) begin
            state         <= IDLE;
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_SHORT;
          end else if (tmo_left == '0) begin
            state         <= DISCARD;
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_TIMEOUT;
          end else begin
            tmo_left <= tmo_left - TCW'(1);
          end
        end
        WAIT_END: begin
          if (bus.byte_valid) begin
            state         <= bus.frame_active ? DISCARD : IDLE;
            frame_error_q <= 1'b1;
            err_code_q    <= ERR_LONG;
          end else if (!bus.frame_active) begin
            state <= IDLE;
            if (ok) begin
              synth_q       <= shadow;
              synth_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
              err_code_q    <= ERR_CHECKSUM;
            end
          end
        end
        DISCARD: begin
          if (!bus.frame_active) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scatter each completed big-endian word into its field of the shadow config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= reset_synth_t();
    end else if (word_wr) begin
      for (int i = 0; i < N_OSC; i++) begin
        for (int j = 0; j < ENV_LEN; j++) begin
          if (word_idx == WIW'(i*STRIDE + 2*j))
            shadow.wave_gens[i].envelopes[j].rate <= word_next;
          if (word_idx == WIW'(i*STRIDE + 2*j + 1))
            shadow.wave_gens[i].envelopes[j].duration <= word_next;
        end
        if (word_idx == WIW'(i*STRIDE + 2*ENV_LEN))
          shadow.wave_gens[i].freq <= word_next;
        if (word_idx == WIW'(i*STRIDE + 2*ENV_LEN + 1))
          shadow.wave_gens[i].shape <= shape_t'(word_next[1:0]);
      end
      if (word_idx == WIW'(N_OSC*STRIDE))
        shadow.reverb <= word_next;
      if (word_idx == WIW'(N_OSC*STRIDE + 1))
        shadow.volume <= word_next;
    end
  end

  assign bus.synth       = synth_q;
  assign bus.synth_valid = synth_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state != IDLE);

endmodule
